// File: rtl/cm151_scan_ctrl.sv
// Scan sequencer for a 74151-style strobed 8:1 mux: walks every select value,
// samples the mux output and hands the assembled word out over valid/ready.
module cm151_scan_ctrl #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  output logic             strobe_n,
  input  logic             mux_in,
  output logic [N_CH-1:0]  word,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  localparam int unsigned     CNT_W    = 4;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              strobe_n_q, strobe_n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   asm_q, asm_d;
  logic [N_CH-1:0]   word_q, word_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      strobe_n_q <= 1'b1;
      cnt_q      <= '0;
      asm_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      strobe_n_q <= strobe_n_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    strobe_n_d = strobe_n_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    word_d     = word_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          sel_d      = '0;
          strobe_n_d = 1'b0;
          cnt_d      = SETTLE_C;
          asm_d      = '0;
        end
      end

      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          asm_d[sel_q] = mux_in;
          if (sel_q != LAST_CH) begin
            sel_d = sel_q + SEL_W'(1);
            cnt_d = SETTLE_C;
          end else begin
            // asm_d already carries the final channel sampled this cycle
            word_d     = asm_d;
            valid_d    = 1'b1;
            strobe_n_d = 1'b1;
            sel_d      = '0;
            state_d    = OUT;
          end
        end
      end

      OUT: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d    = SCAN;
            sel_d      = '0;
            strobe_n_d = 1'b0;
            cnt_d      = SETTLE_C;
            asm_d      = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        sel_d      = '0;
        strobe_n_d = 1'b1;
        cnt_d      = '0;
        valid_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign sel      = sel_q;
  assign strobe_n = strobe_n_q;
  assign word     = word_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cm151_scan_ctrl.sv
// Directed bench for cm151_scan_ctrl: three instances (SETTLE=1,0,2), each
// driven by a behavioural strobed 8:1 mux model m = ~l & data[sel].
module tb_cm151_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start    [3];
  logic       ready    [3];
  logic [7:0] data     [3];
  logic [2:0] sel      [3];
  logic       strobe_n [3];
  logic       mux_in   [3];
  logic [7:0] word     [3];
  logic       valid    [3];
  logic       busy     [3];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign mux_in[g] = ~strobe_n[g] & data[g][sel[g]];

    cm151_scan_ctrl #(
      .N_CH  (8),
      .SEL_W (3),
      .SETTLE((g == 0) ? 1 : ((g == 1) ? 0 : 2))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start[g]),
      .sel     (sel[g]),
      .strobe_n(strobe_n[g]),
      .mux_in  (mux_in[g]),
      .word    (word[g]),
      .valid   (valid[g]),
      .ready   (ready[g]),
      .busy    (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse start for one edge; returns at the negedge after the start edge
  task automatic launch(input int g, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    data[g]  = d;
    start[g] = 1'b1;
    ready[g] = rdy;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  // Walk a scan from just after the start edge up to the edge that raises valid
  task automatic scan_body(input int g, input int s, input logic [7:0] d,
                           input bit tog, input logic [7:0] exp_w);
    int n;
    n = 8 * (s + 1);
    for (int t = 0; t < n; t++) begin
      check("sel_walk", 32'(sel[g]), 32'(t / (s + 1)));
      check("strobe_low", 32'(strobe_n[g]), 32'd0);
      check("valid_early", 32'(valid[g]), 32'd0);
      check("busy_scan", 32'(busy[g]), 32'd1);
      if (tog) data[g] = (((t + 1) % (s + 1)) == 0) ? d : ~d;
      @(negedge clk);
    end
    check("valid_rise", 32'(valid[g]), 32'd1);
    check("word", 32'(word[g]), 32'(exp_w));
    check("strobe_exit", 32'(strobe_n[g]), 32'd1);
    check("sel_exit", 32'(sel[g]), 32'd0);
    check("busy_out", 32'(busy[g]), 32'd1);
  endtask

  task automatic after_handshake(input int g, input logic [7:0] exp_w);
    @(negedge clk);
    check("valid_drop", 32'(valid[g]), 32'd0);
    check("busy_idle", 32'(busy[g]), 32'd0);
    check("strobe_idle", 32'(strobe_n[g]), 32'd1);
    check("word_hold", 32'(word[g]), 32'(exp_w));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      ready[g] = 1'b0;
      data[g]  = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_sel", 32'(sel[g]), 32'd0);
      check("rst_strobe", 32'(strobe_n[g]), 32'd1);
      check("rst_word", 32'(word[g]), 32'd0);
      check("rst_valid", 32'(valid[g]), 32'd0);
      check("rst_busy", 32'(busy[g]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hold", 32'(busy[0]), 32'd0);

    // Basic scan, SETTLE=1
    launch(0, 8'hA5, 1'b1);
    scan_body(0, 1, 8'hA5, 1'b0, 8'hA5);
    after_handshake(0, 8'hA5);

    // SETTLE=0
    launch(1, 8'h3C, 1'b1);
    scan_body(1, 0, 8'h3C, 1'b0, 8'h3C);
    after_handshake(1, 8'h3C);

    // Backpressure with ignored start pulses
    launch(0, 8'hF0, 1'b0);
    scan_body(0, 1, 8'hF0, 1'b0, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(valid[0]), 32'd1);
      check("stall_word", 32'(word[0]), 32'hF0);
      check("stall_strobe", 32'(strobe_n[0]), 32'd1);
      start[0] = (i % 2 == 0);
      @(negedge clk);
    end
    check("stall_valid_end", 32'(valid[0]), 32'd1);
    start[0] = 1'b0;
    ready[0] = 1'b1;
    after_handshake(0, 8'hF0);
    @(negedge clk);
    check("no_rescan", 32'(busy[0]), 32'd0);

    // Back-to-back scans through the handshake edge
    launch(0, 8'hF0, 1'b1);
    scan_body(0, 1, 8'hF0, 1'b0, 8'hF0);
    start[0] = 1'b1;
    data[0]  = 8'h0F;
    @(negedge clk);
    start[0] = 1'b0;
    check("b2b_valid", 32'(valid[0]), 32'd0);
    check("b2b_busy", 32'(busy[0]), 32'd1);
    check("b2b_word_hold", 32'(word[0]), 32'hF0);
    scan_body(0, 1, 8'h0F, 1'b0, 8'h0F);
    after_handshake(0, 8'h0F);

    // Async reset mid-scan
    launch(0, 8'hA5, 1'b1);
    repeat (6) @(negedge clk);
    check("pre_rst_sel", 32'(sel[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel[0]), 32'd0);
    check("arst_strobe", 32'(strobe_n[0]), 32'd1);
    check("arst_valid", 32'(valid[0]), 32'd0);
    check("arst_word", 32'(word[0]), 32'd0);
    check("arst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(0, 8'h81, 1'b1);
    scan_body(0, 1, 8'h81, 1'b0, 8'h81);
    after_handshake(0, 8'h81);

    // SETTLE=2 with data toggling away from the sample points
    launch(2, 8'h55, 1'b1);
    scan_body(2, 2, 8'h55, 1'b1, 8'h55);
    after_handshake(2, 8'h55);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cm151_scan_ctrl.md
Name: cm151_scan_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the 74151-style 8:1 strobed mux in the same benchmark set.
- It drives the mux select lines (i=LSB, j, k=MSB) and the active-low strobe (l).
- It steps through every channel, samples the true-polarity mux output (m), and assembles the samples into one parallel word.
- The word is delivered over a valid/ready handshake, which turns a serial mux read-out into a parallel register snapshot.

Parameters:
- N_CH, 8, number of mux channels scanned (power of two, ≥2).
- SEL_W, 3, select width; must equal log2(N_CH).
- SETTLE, 1, extra wait cycles after each select change before sampling (0..15).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one full scan; level sampled each cycle
- sel  out  SEL_W  mux select; sel[0]→i, sel[1]→j, sel[2]→k
- strobe_n  out  1  mux strobe (l); low only while scanning
- mux_in  in  1  mux output m; forced 0 by the mux while strobe_n=1
- word  out  N_CH  assembled sample word; word[c] = mux_in sampled with sel==c
- valid  out  1  word is available
- ready  in  1  consumer accepts word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release) values: sel=0, strobe_n=1, word=0, valid=0, busy=0, state IDLE, settle counter 0, internal shift/assembly register 0.
- FSM states: IDLE, SCAN, OUT.
- IDLE: on clock edge with start=1, go to SCAN with sel←0, strobe_n←0, cnt←SETTLE, assembly register←0. If start=0, hold.
- SCAN, cnt≠0: cnt←cnt−1. sel and strobe_n are held.
- SCAN, cnt==0: assembly[sel]←mux_in.
  - If sel≠N_CH−1: sel←sel+1, cnt←SETTLE.
  - If sel==N_CH−1: word←assembly with bit N_CH−1 replaced by the current mux_in; valid←1; strobe_n←1; sel←0; go to OUT.
- Each channel occupies SETTLE+1 cycles. valid rises exactly N_CH×(SETTLE+1) clock edges after the start edge (16 for defaults, 8 for SETTLE=0).
- OUT: word and valid are held stable while ready=0 (no limit on stall length).
  - On the edge with valid=1 and ready=1: valid←0.
  - If start=1 on that same edge, enter SCAN directly (sel=0, strobe_n=0, cnt=SETTLE). Otherwise go to IDLE.
  - word keeps its last value after the handshake until the next scan completes.
- start is ignored while in SCAN, and while in OUT without a handshake. It is never queued.
- mux_in is sampled only in SCAN with cnt==0; values at any other time have no effect.
- strobe_n is never low outside SCAN. sel changes only on channel advance, scan entry, or scan exit.
- Reset asserted mid-scan or mid-OUT: all outputs return to reset values immediately. The partial word is discarded and no valid is emitted.
- ready while valid=0 has no effect.

Test Plan:
- Behavioural 8:1 mux model (m = ~l & data[sel]) with data=8'hA5, SETTLE=1, start pulse, ready=1: strobe_n low for exactly 16 cycles; sel walks 0..7, each value held 2 cycles; valid for one cycle 16 edges after start; word=8'hA5; busy high 17 cycles.
- SETTLE=0, data=8'h3C: sel changes every cycle; word=8'h3C; valid 8 edges after start.
- Backpressure: data=8'hF0, ready low for 5 cycles after valid rises; pulse start during the stall: valid and word=8'hF0 stay stable; the start pulses are ignored; after ready=1, valid drops and the FSM returns to IDLE with no new scan.
- Back-to-back: start and ready both high on the handshake edge; data changes to 8'h0F between scans: the next SCAN begins the following cycle; the second word=8'h0F; no IDLE cycle in between.
- Async reset asserted mid-edge while sel=3 in SCAN: sel=0, strobe_n=1, valid=0, word=0, busy=0 immediately. A fresh start with data=8'h81 returns word=8'h81.
- Data toggled on mux data lines while cnt≠0 (SETTLE=2): only the values present at cnt==0 appear in word. Verify with data=8'h55 at sample points and 8'hAA otherwise → word=8'h55.
